// File: rtl/game_sequencer.sv
// game_sequencer: duck-hunt game flow FSM with fire synchronizer, hit test and score keeping.
module game_sequencer #(
    parameter int DUCK_W          = 124,
    parameter int DUCK_H          = 162,
    parameter int SHOTS           = 3,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int MISS_LIMIT      = 3,
    parameter int FLASH_FRAMES    = 30
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic       bullet_active,
    input  logic [9:0] bullet_x,
    input  logic [9:0] bullet_y,
    input  logic [9:0] duck_x,
    input  logic [9:0] duck_y,
    output logic       shot_fire,
    output logic       duck_respawn,
    output logic       duck_enable,
    output logic       flash,
    output logic       game_over,
    output logic [7:0] score,
    output logic [1:0] shots_left,
    output logic [3:0] hits,
    output logic [3:0] misses,
    output logic [2:0] state
);
    typedef enum logic [2:0] {IDLE, RESPAWN, PLAY, HIT_FLASH, MISS, ROUND_END, GAME_OVER} state_t;
    state_t cur, nxt;
    logic [2:0] sync;
    logic [5:0] fcnt;
    logic [10:0] x_hi, y_hi;
    logic fire_edge, hit, tick_done;
    assign state = cur;
    assign fire_edge = sync[1] & ~sync[2];
    assign x_hi = {1'b0, duck_x} + 11'(DUCK_W - 1);
    assign y_hi = {1'b0, duck_y} + 11'(DUCK_H - 1);
    assign hit = bullet_active && bullet_x >= duck_x && {1'b0, bullet_x} <= x_hi
                 && bullet_y >= duck_y && {1'b0, bullet_y} <= y_hi;
    assign tick_done = frame_tick && fcnt == 6'(FLASH_FRAMES - 1);
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            cur  <= IDLE;
            sync <= '0;
        end else begin
            cur  <= nxt;
            sync <= {sync[1:0], fire};
        end
    end
    always_comb begin
        nxt          = cur;
        shot_fire    = 1'b0;
        duck_respawn = 1'b0;
        game_over    = 1'b0;
        case (cur)
            IDLE:      nxt = fire_edge ? RESPAWN : IDLE;
            RESPAWN: begin
                duck_respawn = 1'b1;
                nxt          = PLAY;
            end
            PLAY: begin
                shot_fire = !hit && fire_edge && shots_left != 2'd0 && !bullet_active;
                nxt = hit ? HIT_FLASH : (shots_left == 2'd0 && !bullet_active) ? MISS : PLAY;
            end
            HIT_FLASH: nxt = !tick_done ? HIT_FLASH : (hits == 4'(DUCKS_PER_ROUND)) ? ROUND_END : RESPAWN;
            MISS:      nxt = (4'(misses + 4'd1) == 4'(MISS_LIMIT)) ? GAME_OVER : RESPAWN;
            ROUND_END: nxt = tick_done ? RESPAWN : ROUND_END;
            GAME_OVER: begin
                game_over = 1'b1;
                nxt       = fire_edge ? RESPAWN : GAME_OVER;
            end
            default:   nxt = IDLE;
        endcase
    end
    // Counters and registered indications follow the state being left.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            score       <= '0;
            hits        <= '0;
            misses      <= '0;
            shots_left  <= '0;
            duck_enable <= 1'b0;
            flash       <= 1'b0;
            fcnt        <= '0;
        end else begin
            case (cur)
                IDLE, GAME_OVER: if (fire_edge) begin
                    score  <= '0;
                    hits   <= '0;
                    misses <= '0;
                end
                RESPAWN: begin
                    shots_left  <= 2'(SHOTS);
                    duck_enable <= 1'b1;
                end
                PLAY: if (hit) begin
                    score       <= (score == 8'hFF) ? score : score + 8'd1;
                    hits        <= hits + 4'd1;
                    duck_enable <= 1'b0;
                    flash       <= 1'b1;
                    fcnt        <= '0;
                end else if (shot_fire) begin
                    shots_left <= shots_left - 2'd1;
                end
                HIT_FLASH, ROUND_END: begin
                    if (frame_tick) fcnt <= tick_done ? 6'd0 : fcnt + 6'd1;
                    if (tick_done && cur == HIT_FLASH) flash <= 1'b0;
                    if (tick_done && cur == ROUND_END) begin
                        hits   <= '0;
                        misses <= '0;
                    end
                end
                MISS: begin
                    misses      <= misses + 4'd1;
                    duck_enable <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
